clk_en_gen: RTL
===============

# clk_en_gen

Clock-enable and reset generator that consumes the 46 MHz PLL output and produces every timing strobe the sound core runs on. It conditions the board reset into a clean, held, synchronously released system reset. It then derives single-cycle enables: the YM2612 master clock (≈7.667 MHz), the internal φ clock, the FM sample strobe (≈53.2 kHz) and, optionally, a fractional PSG enable (≈3.58 MHz). All downstream logic runs on `clk` and qualifies work with these enables; no derived clocks exist.

## Interface
- `HOLD_CYCLES`, 1024: `clk` cycles `sys_rst_n` stays low after synchronized reset release (≥1).
- `MCLK_DIV`, 6: `clk` cycles per `cen_mclk` pulse (≥2).
- `PHI_DIV`, 6: `cen_mclk` pulses per `cen_phi` pulse (≥2).
- `SAMPLE_DIV`, 24: `cen_phi` pulses per `cen_sample` pulse (≥2, ≤32).
- `PSG_ACC_W`, 16: PSG phase accumulator width.
- `PSG_INC`, 5100: PSG accumulator increment per `clk` (1 ≤ `PSG_INC` < 2^`PSG_ACC_W`).

- `clk`  in  1  46 MHz system clock from the PLL.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `run`  in  1  1 = strobes advance; 0 = pause, all counters frozen.
- `sys_rst_n`  out  1  Conditioned system reset, active-low.
- `cen_mclk`  out  1  Master-clock enable, one `clk` wide.
- `cen_phi`  out  1  φ enable, one `clk` wide.
- `cen_sample`  out  1  Sample strobe, one `clk` wide.
- `sample_phase`  out  5  Current φ slot within the sample, 0..`SAMPLE_DIV`-1.
- `cen_psg`  out  1  PSG enable, one `clk` wide.

## Operation
- Reset values (async, while `rst_n`=0): `sys_rst_n`=0, all `cen_*`=0, `sample_phase`=0, all counters and accumulator 0.
- Reset conditioner: 2-flop synchronizer (async clear, shifts in 1). After synchronizer output goes high, hold counter counts `HOLD_CYCLES`, then `sys_rst_n` registers to 1 and stays 1 until `rst_n` falls.
- `rst_n` low mid-operation: everything returns to reset values immediately (asynchronous), full hold sequence repeats on release.
- Divider chain held at 0 while `sys_rst_n`=0.
- Prescaler `pre` counts 0..`MCLK_DIV`-1 when `run`=1, wraps to 0. `cen_mclk`=1 in the cycle after `pre` = `MCLK_DIV`-1 advanced (registered output).
- `phi_cnt` advances on each prescaler wrap, 0..`PHI_DIV`-1; `cen_phi` registered on its wrap, coincident with that `cen_mclk`.
- `sample_phase` advances on each φ wrap, 0..`SAMPLE_DIV`-1; `cen_sample` registered on its wrap, coincident with `cen_phi`. `sample_phase` updates in the same cycle `cen_phi` is high (shows new slot; 0 with `cen_sample`).
- Nesting invariant: `cen_sample` ⇒ `cen_phi` ⇒ `cen_mclk`.
- `run`=0: `pre`, `phi_cnt`, `sample_phase`, PSG accumulator hold; all `cen_*` registered 0 next cycle. On `run`=1 counting resumes from held values; no pulse lost or duplicated.
- PSG: accumulator += `PSG_INC` modulo 2^`PSG_ACC_W` each `run` cycle; `cen_psg` = registered carry-out. Average rate = 46 MHz × `PSG_INC` / 2^`PSG_ACC_W`; never two consecutive pulses unless `PSG_INC` ≥ 2^(`PSG_ACC_W`-1).

## Timing
- Reset latency: `sys_rst_n` rises exactly 2 + `HOLD_CYCLES` rising edges after `rst_n` deasserts (±1 for async metastability).
- First `cen_mclk`: cycle `MCLK_DIV`+1 after `sys_rst_n` first samples high with `run`=1; then every `MCLK_DIV` cycles.
- `cen_phi` period `MCLK_DIV`×`PHI_DIV` = 36 cycles; `cen_sample` period 36×`SAMPLE_DIV` = 864 cycles (46 MHz/864 ≈ 53.24 kHz).
- All outputs registered; no combinational path from `run` to outputs.

## Configuration
- `CLK_EN_GEN_PSG_EN` defined: PSG accumulator built, `cen_psg` as above.
- Undefined: accumulator omitted, `cen_psg` tied 0; `PSG_ACC_W`/`PSG_INC` unused. All other behaviour identical.

## Test plan
- Reset: hold `rst_n`=0 10 cycles, release with `HOLD_CYCLES`=1024 → `sys_rst_n` rises at cycle 1026±1; all `cen_*`=0 before.
- Divider cadence, `run`=1 for 10000 cycles → `cen_mclk` every 6, `cen_phi` every 36, `cen_sample` every 864; nesting invariant holds every cycle; `sample_phase` cycles 0..23.
- Pause: drop `run` for 50 cycles at `pre`=3 → no strobes during pause, next `cen_mclk` 3 cycles after `run` returns (gap = 6+50).
- Mid-run reset: assert `rst_n` while `sample_phase`=17 → outputs cleared same cycle; after release, `sample_phase` restarts at 0, first `cen_sample` 864 cycles after first `cen_mclk` window start.
- With `CLK_EN_GEN_PSG_EN`: 2^16 cycles → exactly 5100 `cen_psg` pulses, none adjacent. Without macro → `cen_psg` never 1.
- Parameter sweep `MCLK_DIV`=2, `PHI_DIV`=2, `SAMPLE_DIV`=2 → `cen_sample` every 8 cycles, `cen_mclk` every 2.

Source files
------------

// File: rtl/clk_en_gen.sv
// clk_en_gen: reset conditioner and clock-enable generator for the sound core.
// Takes the 46 MHz PLL clock and the board reset, produces a clean held
// system reset, and derives single-cycle enables: master clock (cen_mclk),
// phi clock (cen_phi), FM sample strobe (cen_sample) with the current phi
// slot (sample_phase), and an optional fractional PSG enable (cen_psg).
// Optional feature macro: CLK_EN_GEN_PSG_EN builds the PSG phase
// accumulator; without it cen_psg is tied low.
module clk_en_gen #(
    parameter int HOLD_CYCLES = 1024,
    parameter int MCLK_DIV    = 6,
    parameter int PHI_DIV     = 6,
    parameter int SAMPLE_DIV  = 24,
    parameter int PSG_ACC_W   = 16,
    parameter int PSG_INC     = 5100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       sys_rst_n,
    output logic       cen_mclk,
    output logic       cen_phi,
    output logic       cen_sample,
    output logic [4:0] sample_phase,
    output logic       cen_psg
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int PRE_W  = $clog2(MCLK_DIV);
    localparam int PHI_W  = $clog2(PHI_DIV);

    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(MCLK_DIV - 1);
    localparam logic [PHI_W-1:0]  PHI_LAST   = PHI_W'(PHI_DIV - 1);
    localparam logic [4:0]        PHASE_LAST = 5'(SAMPLE_DIV - 1);

    // Elaboration-time parameter range checks
    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $error("clk_en_gen: HOLD_CYCLES must be >= 1");
    end
    if (MCLK_DIV < 2) begin : g_chk_mclk
        $error("clk_en_gen: MCLK_DIV must be >= 2");
    end
    if (PHI_DIV < 2) begin : g_chk_phi
        $error("clk_en_gen: PHI_DIV must be >= 2");
    end
    if ((SAMPLE_DIV < 2) || (SAMPLE_DIV > 32)) begin : g_chk_sample
        $error("clk_en_gen: SAMPLE_DIV must be in 2..32");
    end
    if ((PSG_ACC_W < 1) || (PSG_INC < 1) || (PSG_INC >= (1 << PSG_ACC_W))) begin : g_chk_psg
        $error("clk_en_gen: PSG_INC must be in 1..2^PSG_ACC_W-1");
    end

    // ------------------------------------------------------------------
    // Reset conditioner
    // ------------------------------------------------------------------
    logic [1:0]        sync_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              sys_rst_n_r;

    // Two-flop synchronizer: clears asynchronously, releases after two edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], 1'b1};
        end
    end

    // Hold counter keeps the system reset asserted HOLD_CYCLES edges past sync release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r  <= {HOLD_W{1'b0}};
            sys_rst_n_r <= 1'b0;
        end else if (sync_r[1] && !sys_rst_n_r) begin
            if (hold_cnt_r == HOLD_LAST) begin
                sys_rst_n_r <= 1'b1;
            end else begin
                hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Divider chain: pre -> phi_cnt -> sample_phase
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] pre_r;
    logic [PHI_W-1:0] phi_cnt_r;
    logic [4:0]       sample_phase_r;
    logic             cen_mclk_r;
    logic             cen_phi_r;
    logic             cen_sample_r;

    logic             adv_s;
    logic             pre_wrap_s;
    logic             phi_wrap_s;
    logic             smp_wrap_s;
    logic [PRE_W-1:0] pre_nxt_s;
    logic [PHI_W-1:0] phi_nxt_s;
    logic [4:0]       phase_nxt_s;

    // Next-state of the cascaded counters; each stage only moves on the wrap of the one below
    always_comb begin
        adv_s       = sys_rst_n_r & run;
        pre_wrap_s  = adv_s & (pre_r == PRE_LAST);
        phi_wrap_s  = pre_wrap_s & (phi_cnt_r == PHI_LAST);
        smp_wrap_s  = phi_wrap_s & (sample_phase_r == PHASE_LAST);
        pre_nxt_s   = pre_r;
        phi_nxt_s   = phi_cnt_r;
        phase_nxt_s = sample_phase_r;

        if (!adv_s) begin
            pre_nxt_s = pre_r;
        end else if (pre_wrap_s) begin
            pre_nxt_s = {PRE_W{1'b0}};
        end else begin
            pre_nxt_s = pre_r + PRE_W'(1);
        end

        if (!pre_wrap_s) begin
            phi_nxt_s = phi_cnt_r;
        end else if (phi_wrap_s) begin
            phi_nxt_s = {PHI_W{1'b0}};
        end else begin
            phi_nxt_s = phi_cnt_r + PHI_W'(1);
        end

        if (!phi_wrap_s) begin
            phase_nxt_s = sample_phase_r;
        end else if (smp_wrap_s) begin
            phase_nxt_s = 5'd0;
        end else begin
            phase_nxt_s = sample_phase_r + 5'd1;
        end
    end

    // Counter and strobe registers; held at zero until the system reset releases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r          <= {PRE_W{1'b0}};
            phi_cnt_r      <= {PHI_W{1'b0}};
            sample_phase_r <= 5'd0;
            cen_mclk_r     <= 1'b0;
            cen_phi_r      <= 1'b0;
            cen_sample_r   <= 1'b0;
        end else if (!sys_rst_n_r) begin
            pre_r          <= {PRE_W{1'b0}};
            phi_cnt_r      <= {PHI_W{1'b0}};
            sample_phase_r <= 5'd0;
            cen_mclk_r     <= 1'b0;
            cen_phi_r      <= 1'b0;
            cen_sample_r   <= 1'b0;
        end else begin
            pre_r          <= pre_nxt_s;
            phi_cnt_r      <= phi_nxt_s;
            sample_phase_r <= phase_nxt_s;
            cen_mclk_r     <= pre_wrap_s;
            cen_phi_r      <= phi_wrap_s;
            cen_sample_r   <= smp_wrap_s;
        end
    end

    // ------------------------------------------------------------------
    // PSG fractional enable
    // ------------------------------------------------------------------
`ifdef CLK_EN_GEN_PSG_EN
    localparam int                SUM_W       = PSG_ACC_W + 1;
    localparam logic [SUM_W-1:0]  PSG_INC_EXT = SUM_W'(PSG_INC);

    logic [PSG_ACC_W-1:0] psg_acc_r;
    logic [SUM_W-1:0]     psg_sum_s;
    logic                 cen_psg_r;

    // Accumulator sum with carry; the carry is the PSG pulse
    always_comb begin
        psg_sum_s = {1'b0, psg_acc_r} + PSG_INC_EXT;
    end

    // Phase accumulator advances once per running cycle, carry registered as the enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psg_acc_r <= {PSG_ACC_W{1'b0}};
            cen_psg_r <= 1'b0;
        end else if (!sys_rst_n_r) begin
            psg_acc_r <= {PSG_ACC_W{1'b0}};
            cen_psg_r <= 1'b0;
        end else if (run) begin
            psg_acc_r <= psg_sum_s[PSG_ACC_W-1:0];
            cen_psg_r <= psg_sum_s[PSG_ACC_W];
        end else begin
            cen_psg_r <= 1'b0;
        end
    end

    assign cen_psg = cen_psg_r;
`else
    assign cen_psg = 1'b0;
`endif

    assign sys_rst_n    = sys_rst_n_r;
    assign cen_mclk     = cen_mclk_r;
    assign cen_phi      = cen_phi_r;
    assign cen_sample   = cen_sample_r;
    assign sample_phase = sample_phase_r;

endmodule
